// File: rtl/eq_fir_mac_if.sv
// Sample/coefficient/result bus of the equalizer serial-MAC FIR.
// master = the stream source/sink side, slave = the filter.
interface eq_fir_mac_if #(
  parameter int DW = 16,
  parameter int CW = 16
);
  logic          coef_valid;
  logic [CW-1:0] tapcoeff;
  logic [7:0]    tapnum;
  logic          coef_commit;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic          sample_ready;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          busy;

  modport master (
    output coef_valid, tapcoeff, tapnum, coef_commit, sample_valid, sample_in,
    input  sample_ready, out_valid, out_sample, busy
  );

  modport slave (
    input  coef_valid, tapcoeff, tapnum, coef_commit, sample_valid, sample_in,
    output sample_ready, out_valid, out_sample, busy
  );
endinterface

// File: rtl/eq_fir_mac.sv
// Serial-MAC FIR with shadow/active coefficient banks and a circular delay line.
// Define FIR_SAT_EN to saturate the rounded result to DW bits instead of wrapping.
module eq_fir_mac #(
  parameter int NTAPS = 64,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = 40
) (
  input  logic         clk,
  input  logic         reset,
  eq_fir_mac_if.slave  bus
);
  localparam int AW = $clog2(NTAPS);
  localparam int KW = $clog2(NTAPS + 1);
  localparam logic signed [ACCW-1:0] RND_HALF = {{(ACCW-15){1'b0}}, 1'b1, 14'b0};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                 state, state_nxt;
  logic signed [CW-1:0]   shadow     [NTAPS];
  logic signed [CW-1:0]   shadow_nxt [NTAPS];
  logic signed [CW-1:0]   active     [NTAPS];
  logic signed [DW-1:0]   xline      [NTAPS];
  logic [AW-1:0]          wptr, rd_idx;
  logic [KW-1:0]          k;
  logic                   commit_pending;
  logic signed [CW-1:0]   c_q;
  logic signed [DW-1:0]   x_q;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   r, r_nxt;
  logic [DW-1:0]          out_sample_q;
  logic                   out_valid_q;
  logic                   accept, do_copy, last_mac;

  assign accept   = bus.sample_valid && (state == IDLE);
  assign do_copy  = (state == IDLE) && commit_pending;
  assign last_mac = (state == MAC) && (k == KW'(NTAPS));
  assign prod     = (DW+CW)'(c_q) * (DW+CW)'(x_q);

  assign bus.sample_ready = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sample   = out_sample_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (last_mac) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Forwarded shadow contents so a write landing in the copy cycle is still promoted.
  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      shadow_nxt[i] = shadow[i];
      if (bus.coef_valid && (bus.tapnum == 8'(i))) shadow_nxt[i] = bus.tapcoeff;
    end
  end

  // NOTE: the coefficient banks and delay line are reset explicitly, so they map to flops, not RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (do_copy) active[i] <= shadow_nxt[i];
      end
      if (bus.coef_commit)  commit_pending <= 1'b1;
      else if (do_copy)     commit_pending <= 1'b0;
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACCW-1:0] shifted;

  assign shifted = (acc + RND_HALF) >>> 15;

  always_comb begin
    if (shifted > SAT_MAX)      r_nxt = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN) r_nxt = {1'b1, {(DW-1){1'b0}}};
    else                        r_nxt = shifted[DW-1:0];
  end
`else
  assign r_nxt = DW'((acc + RND_HALF) >>> 15);
`endif

  // MAC step k registers tap k's operands; the product is accumulated one step later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) xline[i] <= '0;
      wptr         <= '0;
      rd_idx       <= '0;
      k            <= '0;
      c_q          <= '0;
      x_q          <= '0;
      acc          <= '0;
      r            <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          xline[wptr] <= bus.sample_in;
          wptr        <= (wptr == AW'(NTAPS-1)) ? '0 : wptr + AW'(1);
          rd_idx      <= wptr;
          acc         <= '0;
          k           <= '0;
        end
        MAC: begin
          if (k < KW'(NTAPS)) begin
            c_q    <= active[k[AW-1:0]];
            x_q    <= xline[rd_idx];
            rd_idx <= (rd_idx == '0) ? AW'(NTAPS-1) : rd_idx - AW'(1);
          end
          if (k != '0) acc <= acc + ACCW'(prod);
          k <= k + KW'(1);
        end
        ROUND: r <= r_nxt;
        OUT: begin
          out_sample_q <= r;
          out_valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
